// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
package decoder_pkg;

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BLANK} scan_state_t;

  // Highest select code for an n-bit decoder select bus.
  function automatic int unsigned sel_max(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable up-counter: counts 0..last and flags the terminal value.
module scan_dwell_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Sweeps a decoder select code 0..top, holding each code for DWELL_CYCLES clocks.
// Optional inter-code blanking gap is enabled with the SCAN_BLANKING_EN macro.
module decoder_scan_sequencer
  import decoder_pkg::*;
#(
  parameter int NUM_OF_BITS  = 2,
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  output logic [NUM_OF_BITS-1:0] a,
  output logic                   ena,
  output logic                   busy,
  output logic                   sweep_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]       DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [NUM_OF_BITS-1:0] TOP_CODE   = NUM_OF_BITS'(sel_max(NUM_OF_BITS));

  scan_state_t            state, state_n;
  logic [NUM_OF_BITS-1:0] a_n;
  logic                   ena_n, busy_n, done_n;
  logic                   tmr_clear, tmr_en, tmr_tc;
  logic [CNT_W-1:0]       tmr_last;

`ifdef SCAN_BLANKING_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  assign tmr_last = (state == S_BLANK) ? BLANK_LAST : DWELL_LAST;
`else
  assign tmr_last = DWELL_LAST;
`endif

  scan_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .en    (tmr_en),
    .last  (tmr_last),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      a          <= '0;
      ena        <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_n;
      a          <= a_n;
      ena        <= ena_n;
      busy       <= busy_n;
      sweep_done <= done_n;
    end
  end

  // Outputs are computed one cycle ahead so a and ena update on the same edge.
  always_comb begin
    state_n   = state;
    a_n       = a;
    ena_n     = ena;
    busy_n    = busy;
    done_n    = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;

    case (state)
      S_IDLE: begin
        a_n       = '0;
        ena_n     = 1'b0;
        busy_n    = 1'b0;
        tmr_clear = 1'b1;
        if (start && !stop) begin
          state_n = S_DWELL;
          ena_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end

      S_DWELL: begin
        if (stop) begin
          state_n   = S_IDLE;
          a_n       = '0;
          ena_n     = 1'b0;
          busy_n    = 1'b0;
          tmr_clear = 1'b1;
        end else if (tmr_tc) begin
          tmr_clear = 1'b1;
          if (a != TOP_CODE) begin
`ifdef SCAN_BLANKING_EN
            state_n = S_BLANK;
            ena_n   = 1'b0;
`else
            a_n     = a + NUM_OF_BITS'(1);
`endif
          end else begin
            done_n = 1'b1;
            if (continuous) begin
`ifdef SCAN_BLANKING_EN
              state_n = S_BLANK;
              ena_n   = 1'b0;
`else
              a_n     = '0;
`endif
            end else begin
              state_n = S_IDLE;
              a_n     = '0;
              ena_n   = 1'b0;
              busy_n  = 1'b0;
            end
          end
        end else begin
          tmr_en = 1'b1;
        end
      end

`ifdef SCAN_BLANKING_EN
      S_BLANK: begin
        if (stop) begin
          state_n   = S_IDLE;
          a_n       = '0;
          ena_n     = 1'b0;
          busy_n    = 1'b0;
          tmr_clear = 1'b1;
        end else if (tmr_tc) begin
          // Advancing modulo 2**NUM_OF_BITS covers the continuous wrap from top to 0.
          tmr_clear = 1'b1;
          state_n   = S_DWELL;
          a_n       = a + NUM_OF_BITS'(1);
          ena_n     = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
`endif

      default: begin
        state_n   = S_IDLE;
        a_n       = '0;
        ena_n     = 1'b0;
        busy_n    = 1'b0;
        tmr_clear = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed self-checking bench for decoder_scan_sequencer (default parameters).
module tb_decoder_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] a;
  logic       ena, busy, sweep_done;

  int n_cmp = 0;
  int n_err = 0;

  decoder_scan_sequencer #(
    .NUM_OF_BITS  (2),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .a          (a),
    .ena        (ena),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] ea, input logic eena,
                           input logic ebusy, input logic edone);
    check({tag, ".a"},    32'(a),          32'(ea));
    check({tag, ".ena"},  32'(ena),        32'(eena));
    check({tag, ".busy"}, 32'(busy),       32'(ebusy));
    check({tag, ".done"}, 32'(sweep_done), 32'(edone));
  endtask

  initial begin
    // Test 1: reset, then hold idle with start low.
    step(); step();
    rst = 1'b0;
    step();
    check_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    step(); step();
    check_out("idle_hold", 2'd0, 1'b0, 1'b0, 1'b0);

    // Test 2: single sweep; start seen at cycle 0, observation after step k is cycle k.
    continuous = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      start = 1'b0;
      if (c <= 16)
        check_out($sformatf("single_c%0d", c), 2'((c - 1) / 4), 1'b1, 1'b1, 1'b0);
      else if (c == 17)
        check_out("single_c17", 2'd0, 1'b0, 1'b0, 1'b1);
      else
        check_out("single_c18", 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // Test 3: continuous sweep, three wraps, then stop.
    continuous = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      step();
      start = 1'b0;
      check_out($sformatf("cont_c%0d", c), 2'(((c - 1) / 4) % 4), 1'b1, 1'b1,
                (c == 17 || c == 33 || c == 49));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    continuous = 1'b0;
    check_out("cont_stop", 2'd0, 1'b0, 1'b0, 1'b0);

    // Test 4: stop during code 1 at cycle 6.
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
    end
    check_out("stop_c6", 2'd1, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_out("stop_c7", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 8; c <= 20; c++) begin
      step();
      check_out($sformatf("stop_after_c%0d", c), 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    step();
    check_out("startstop_1", 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    start = 1'b0;
    stop  = 1'b0;
    check_out("startstop_2", 2'd0, 1'b0, 1'b0, 1'b0);

    // Test 5: reset mid-sweep at cycle 10.
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = 1'b0;
    end
    check_out("rst_c10", 2'd2, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_out("rst_c11", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 12; c <= 24; c++) begin
      step();
      check_out($sformatf("rst_after_c%0d", c), 2'd0, 1'b0, 1'b0, 1'b0);
    end

`ifdef SCAN_BLANKING_EN
    // Test 6: single sweep with one-cycle blanks between codes.
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      start = 1'b0;
      if (c == 5 || c == 10 || c == 15)
        check_out($sformatf("blank_c%0d", c), 2'((c - 5) / 5), 1'b0, 1'b1, 1'b0);
      else if (c <= 19)
        check_out($sformatf("blank_c%0d", c), 2'((c - 1) / 5), 1'b1, 1'b1, 1'b0);
      else if (c == 20)
        check_out("blank_c20", 2'd0, 1'b0, 1'b0, 1'b1);
      else
        check_out("blank_c21", 2'd0, 1'b0, 1'b0, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
